nested_stack_guard: RTL and testbench

- Parametrised successor to the single-frame UCC stack write guard.
- Tracks a LIFO of base pointers, so nested UCC invocations each get their own protected frame.
- Flags writes at or above the current frame base, shadow-stack overflow/underflow, and enter/exit protocol errors.
- Sits beside the CPU data bus and drives the hardware reset request. The UCC state FSM feeds it state and entry/exit pulses.

---
 rtl/nested_stack_guard_pkg.sv | 20 ++
 rtl/nested_stack_guard_stack.sv | 48 ++++
 rtl/nested_stack_guard.sv | 95 +++++++++
 tb/tb_nested_stack_guard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nested_stack_guard_pkg.sv
// Shared encodings for the nested UCC stack guard: UCC FSM states and violation cause codes.
package nested_stack_guard_pkg;

  typedef enum logic [1:0] {
    ST_NOT_UCC = 2'b00,
    ST_IN_UCC  = 2'b01,
    ST_IRQ     = 2'b10,
    ST_RST     = 2'b11
  } ucc_state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'b000,
    CAUSE_WR    = 3'b001,
    CAUSE_OVF   = 3'b010,
    CAUSE_UNF   = 3'b011,
    CAUSE_PROTO = 3'b100,
    CAUSE_LIM   = 3'b101
  } cause_e;

endpackage

// File: rtl/nested_stack_guard_stack.sv
// LIFO of saved frame base pointers; level doubles as the nesting depth.
module bp_shadow_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         system_reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         full,
  output logic                         empty
);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_m1;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign level_m1 = level_q - LVL_W'(1);
  assign wr_idx   = level_q[IDX_W-1:0];
  assign rd_idx   = level_m1[IDX_W-1:0];
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign top_data = mem[rd_idx];
  assign level    = level_q;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      level_q <= '0;
    end else if (push && !full) begin
      level_q <= level_q + LVL_W'(1);
    end else if (pop && !empty) begin
      level_q <= level_m1;
    end
  end

endmodule

// File: rtl/nested_stack_guard.sv
// Nested UCC stack write guard: per-frame base pointers, protocol checks, reset request.
// Optional NESTED_STACK_GUARD_LOWER_BOUND_EN adds a STACK_LIMIT floor on checked writes.
module nested_stack_guard
  import nested_stack_guard_pkg::*;
#(
  parameter int                ADDR_W        = 16,
  parameter int                DEPTH         = 4,
  parameter logic [ADDR_W-1:0] RESET_HANDLER = '0
`ifdef NESTED_STACK_GUARD_LOWER_BOUND_EN
  , parameter logic [ADDR_W-1:0] STACK_LIMIT = '0
`endif
) (
  input  logic                       clk,
  input  logic                       system_reset,
  input  logic [ADDR_W-1:0]          data_addr,
  input  logic                       data_wr,
  input  logic [ADDR_W-1:0]          pc,
  input  logic [ADDR_W-1:0]          stack_pointer,
  input  logic                       outside_ucc,
  input  logic [1:0]                 ucc_state,
  input  logic                       ucc_enter,
  input  logic                       ucc_exit,
  output logic                       reset,
  output logic [ADDR_W-1:0]          base_pointer,
  output logic [$clog2(DEPTH+1)-1:0] nest_level,
  output logic [2:0]                 viol_cause
);
  logic              in_rst, rel_ok, active, rst_hold;
  logic              do_push, do_pop, ovf, unf, proto;
  logic              wr_chk, wr_viol, lim_viol;
  logic              full, empty;
  logic [ADDR_W-1:0] top_data;
  cause_e            cause_now, cause_q;

  assign in_rst   = (ucc_state == ST_RST);
  assign rel_ok   = in_rst && (pc == RESET_HANDLER) && !data_wr;
  assign active   = !in_rst || rel_ok;
  assign rst_hold = in_rst && !rel_ok;

  assign do_push = active && ucc_enter && !ucc_exit && !full;
  assign do_pop  = active && ucc_exit && !ucc_enter && !empty;
  assign ovf     = active && ucc_enter && !ucc_exit && full;
  assign unf     = active && ucc_exit && !ucc_enter && empty;
  assign proto   = active && ucc_enter && ucc_exit;

  // Compared against the base in force this cycle, before any push/pop lands.
  assign wr_chk  = !in_rst && !outside_ucc && data_wr;
  assign wr_viol = wr_chk && (data_addr >= base_pointer);
`ifdef NESTED_STACK_GUARD_LOWER_BOUND_EN
  assign lim_viol = wr_chk && (data_addr < STACK_LIMIT);
`else
  assign lim_viol = 1'b0;
`endif

  always_comb begin
    cause_now = CAUSE_NONE;
    if (wr_viol)       cause_now = CAUSE_WR;
    else if (lim_viol) cause_now = CAUSE_LIM;
    else if (proto)    cause_now = CAUSE_PROTO;
    else if (ovf)      cause_now = CAUSE_OVF;
    else if (unf)      cause_now = CAUSE_UNF;
  end

  bp_shadow_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk          (clk),
    .system_reset (system_reset),
    .push         (do_push),
    .pop          (do_pop),
    .push_data    (base_pointer),
    .top_data     (top_data),
    .level        (nest_level),
    .full         (full),
    .empty        (empty)
  );

  always_ff @(posedge clk) begin
    if (system_reset) begin
      reset        <= 1'b1;
      base_pointer <= '0;
      cause_q      <= CAUSE_NONE;
    end else begin
      reset <= (cause_now != CAUSE_NONE) || rst_hold;
      if (do_push)                           base_pointer <= stack_pointer;
      else if (do_pop)                       base_pointer <= top_data;
      else if (active && empty && outside_ucc) base_pointer <= stack_pointer;
      if (cause_q == CAUSE_NONE) cause_q <= cause_now;
    end
  end

  assign viol_cause = cause_q;

endmodule

// File: tb/tb_nested_stack_guard.sv
// Bench for nested_stack_guard: directed table, hand sequences, then random traffic vs a queue model.
module tb_nested_stack_guard;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        system_reset, data_wr, outside_ucc, ucc_enter, ucc_exit;
  logic [15:0] data_addr, pc, stack_pointer;
  logic [1:0]  ucc_state;
  logic        reset;
  logic [15:0] base_pointer;
  logic [2:0]  nest_level, viol_cause;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nested_stack_guard dut (
    .clk           (clk),
    .system_reset  (system_reset),
    .data_addr     (data_addr),
    .data_wr       (data_wr),
    .pc            (pc),
    .stack_pointer (stack_pointer),
    .outside_ucc   (outside_ucc),
    .ucc_state     (ucc_state),
    .ucc_enter     (ucc_enter),
    .ucc_exit      (ucc_exit),
    .reset         (reset),
    .base_pointer  (base_pointer),
    .nest_level    (nest_level),
    .viol_cause    (viol_cause)
  );

  typedef struct {
    logic        sysrst;
    logic [1:0]  st;
    logic [15:0] pc, sp, addr;
    logic        wr, outside, en, ex;
    logic        exp_reset;
    logic [15:0] exp_bp;
    logic [2:0]  exp_lvl, exp_cause;
  } vec_t;

  // Reference model: saved bases in a queue, nesting depth is its size.
  logic [15:0] m_shadow[$];
  logic [15:0] m_bp = '0;
  logic        m_reset = 1'b1;
  logic [2:0]  m_cause = '0;

  function automatic vec_t mk(input logic sr, input logic [1:0] st, input logic [15:0] p,
                              input logic [15:0] sp, input logic [15:0] a, input logic w,
                              input logic o, input logic en, input logic ex,
                              input logic er, input logic [15:0] eb, input logic [2:0] el,
                              input logic [2:0] ec);
    vec_t v;
    v.sysrst = sr; v.st = st; v.pc = p; v.sp = sp; v.addr = a; v.wr = w;
    v.outside = o; v.en = en; v.ex = ex;
    v.exp_reset = er; v.exp_bp = eb; v.exp_lvl = el; v.exp_cause = ec;
    return v;
  endfunction

  task automatic model_step(input vec_t v);
    bit in_rst, rel, act;
    logic [2:0] c;
    if (v.sysrst) begin
      m_reset = 1'b1; m_bp = '0; m_cause = '0; m_shadow.delete();
      return;
    end
    in_rst = (v.st == 2'b11);
    rel    = in_rst && v.pc == 16'h0000 && !v.wr;
    act    = !in_rst || rel;
    c = 3'd0;
    if (!in_rst && !v.outside && v.wr && v.addr >= m_bp) c = 3'd1;
    else if (act && v.en && v.ex)                        c = 3'd4;
    else if (act && v.en && m_shadow.size() == DEPTH)    c = 3'd2;
    else if (act && v.ex && m_shadow.size() == 0)        c = 3'd3;
    if (act && v.en && !v.ex && m_shadow.size() < DEPTH) begin
      m_shadow.push_back(m_bp);
      m_bp = v.sp;
    end else if (act && v.ex && !v.en && m_shadow.size() > 0) begin
      m_bp = m_shadow.pop_back();
    end else if (act && m_shadow.size() == 0 && v.outside) begin
      m_bp = v.sp;
    end
    m_reset = (c != 3'd0) || (in_rst && !rel);
    if (m_cause == 3'd0) m_cause = c;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit use_model, input string tag);
    system_reset = v.sysrst; ucc_state = v.st; pc = v.pc; stack_pointer = v.sp;
    data_addr = v.addr; data_wr = v.wr; outside_ucc = v.outside;
    ucc_enter = v.en; ucc_exit = v.ex;
    model_step(v);
    @(posedge clk);
    #1;
    if (use_model) begin
      check({tag, ".reset"}, 16'(reset), 16'(m_reset));
      check({tag, ".bp"}, base_pointer, m_bp);
      check({tag, ".lvl"}, 16'(nest_level), 16'(m_shadow.size()));
      check({tag, ".cause"}, 16'(viol_cause), 16'(m_cause));
    end else begin
      check({tag, ".reset"}, 16'(reset), 16'(v.exp_reset));
      check({tag, ".bp"}, base_pointer, v.exp_bp);
      check({tag, ".lvl"}, 16'(nest_level), 16'(v.exp_lvl));
      check({tag, ".cause"}, 16'(viol_cause), 16'(v.exp_cause));
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [15:0] sp_i;

    system_reset = 1'b1; ucc_state = 2'b00; pc = '0; stack_pointer = '0;
    data_addr = '0; data_wr = 1'b0; outside_ucc = 1'b1; ucc_enter = 1'b0; ucc_exit = 1'b0;

    // Reset release, level-0 tracking, write checks and two-deep nesting
    tbl.push_back(mk(1,2'd0,16'h0000,16'h0000,16'h0000,0,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h0000,16'h0400,16'h0000,0,1,0,0, 0,16'h0400,3'd0,3'd0));
    tbl.push_back(mk(0,2'd0,16'h0100,16'h0400,16'h0000,0,1,0,0, 0,16'h0400,3'd0,3'd0));
    tbl.push_back(mk(0,2'd0,16'h0100,16'h0400,16'h0000,0,1,1,0, 0,16'h0400,3'd1,3'd0));
    tbl.push_back(mk(0,2'd1,16'h0110,16'h03F0,16'h03FE,1,0,0,0, 0,16'h0400,3'd1,3'd0));
    tbl.push_back(mk(0,2'd1,16'h0120,16'h0380,16'h0000,0,0,1,0, 0,16'h0380,3'd2,3'd0));
    tbl.push_back(mk(0,2'd1,16'h0130,16'h0370,16'h0390,1,0,0,0, 1,16'h0380,3'd2,3'd1));
    tbl.push_back(mk(0,2'd1,16'h0140,16'h0370,16'h0000,0,0,0,1, 0,16'h0400,3'd1,3'd1));
    tbl.push_back(mk(0,2'd1,16'h0150,16'h03F0,16'h0390,1,0,0,0, 0,16'h0400,3'd1,3'd1));
    tbl.push_back(mk(0,2'd1,16'h0160,16'h03F0,16'h0400,1,0,0,0, 1,16'h0400,3'd1,3'd1));
    // Underflow on a fresh run
    tbl.push_back(mk(1,2'd0,16'h0000,16'h0000,16'h0000,0,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h0000,16'h0400,16'h0000,0,1,0,0, 0,16'h0400,3'd0,3'd0));
    tbl.push_back(mk(0,2'd0,16'h0200,16'h0400,16'h0000,0,1,0,1, 1,16'h0400,3'd0,3'd3));
    tbl.push_back(mk(0,2'd0,16'h0200,16'h0410,16'h0000,0,1,0,0, 0,16'h0410,3'd0,3'd3));
    // Simultaneous enter+exit
    tbl.push_back(mk(1,2'd0,16'h0000,16'h0000,16'h0000,0,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h0000,16'h0400,16'h0000,0,1,0,0, 0,16'h0400,3'd0,3'd0));
    tbl.push_back(mk(0,2'd0,16'h0300,16'h0400,16'h0000,0,1,1,0, 0,16'h0400,3'd1,3'd0));
    tbl.push_back(mk(0,2'd1,16'h0310,16'h0300,16'h0000,0,0,1,1, 1,16'h0400,3'd1,3'd4));
    // RST hold: wrong pc, ignored pulse, write at handler, then release
    tbl.push_back(mk(1,2'd0,16'h0000,16'h0000,16'h0000,0,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h1234,16'h0400,16'h0000,0,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h1234,16'h0400,16'h0000,0,1,1,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h0000,16'h0400,16'h0000,1,1,0,0, 1,16'h0000,3'd0,3'd0));
    tbl.push_back(mk(0,2'd3,16'h0000,16'h0400,16'h0000,0,1,0,0, 0,16'h0400,3'd0,3'd0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0, $sformatf("tbl%0d", i));

    // Overflow: DEPTH enters fill the stack, the next one is refused
    apply(mk(1,2'd0,16'h0,16'h0,16'h0,0,1,0,0, 1,16'h0000,3'd0,3'd0), 1'b0, "ovf_rst");
    apply(mk(0,2'd3,16'h0,16'h0500,16'h0,0,1,0,0, 0,16'h0500,3'd0,3'd0), 1'b0, "ovf_rel");
    for (int i = 0; i < DEPTH; i++) begin
      sp_i = 16'h0400 - 16'(i * 16'h0100);
      apply(mk(0,2'd1,16'h0100,sp_i,16'h0,0,0,1,0, 0,sp_i,3'(i + 1),3'd0), 1'b0,
            $sformatf("ovf_push%0d", i));
    end
    apply(mk(0,2'd1,16'h0100,16'h0050,16'h0,0,0,1,0, 1,16'h0100,3'd4,3'd2), 1'b0, "ovf_hit");
    apply(mk(0,2'd2,16'h0100,16'h0050,16'h0,0,0,0,1, 0,16'h0200,3'd3,3'd2), 1'b0, "ovf_pop");

    // Write violation and overflow in one cycle: WR wins
    apply(mk(1,2'd0,16'h0,16'h0,16'h0,0,1,0,0, 1,16'h0000,3'd0,3'd0), 1'b0, "wo_rst");
    apply(mk(0,2'd3,16'h0,16'h0800,16'h0,0,1,0,0, 0,16'h0800,3'd0,3'd0), 1'b0, "wo_rel");
    for (int i = 0; i < DEPTH; i++) begin
      sp_i = 16'h0700 - 16'(i * 16'h0010);
      apply(mk(0,2'd1,16'h0100,sp_i,16'h0,0,0,1,0, 0,sp_i,3'(i + 1),3'd0), 1'b0,
            $sformatf("wo_push%0d", i));
    end
    apply(mk(0,2'd1,16'h0100,16'h0600,16'h06D0,1,0,1,0, 1,16'h06D0,3'd4,3'd1), 1'b0, "wo_hit");

    // Random traffic against the model
    apply(mk(1,2'd0,16'h0,16'h0,16'h0,0,1,0,0, 1,16'h0,3'd0,3'd0), 1'b1, "rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      v.sysrst  = ($urandom_range(0, 99) < ((m_cause != 3'd0) ? 6 : 1));
      v.st      = ($urandom_range(0, 9) < 2) ? 2'b11 : 2'($urandom_range(0, 2));
      v.pc      = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
      v.sp      = 16'($urandom);
      v.addr    = 16'($urandom);
      v.wr      = ($urandom_range(0, 3) == 0);
      v.outside = ($urandom_range(0, 1) == 0);
      v.en      = ($urandom_range(0, 3) == 0);
      v.ex      = ($urandom_range(0, 4) == 0);
      v.exp_reset = 1'b0; v.exp_bp = '0; v.exp_lvl = '0; v.exp_cause = '0;
      apply(v, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
